// File: rtl/life_pkg.sv
// Shared types and helpers for the Life generation engine: FSM states,
// generation-counter width, population count and the per-cell Life rule.
package life_pkg;

    localparam int GEN_W     = 16;
    localparam int POP_MAX_W = 256;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        PRIME0  = 4'd1,
        PRIME1  = 4'd2,
        PRIME2  = 4'd3,
        PRIME3  = 4'd4,
        FETCH   = 4'd5,
        CAPTURE = 4'd6,
        WRITE   = 4'd7,
        DONE    = 4'd8
    } life_state_e;

    // Callers zero-extend narrower rows into the fixed-width argument.
    function automatic logic [8:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [8:0] cnt;
        cnt = 9'd0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            cnt = cnt + 9'(v[i]);
        end
        return cnt;
    endfunction

    // nbhd[2:0] = top row, nbhd[5:3] = own row, nbhd[8:6] = bottom row; bit 4 is the cell.
    function automatic logic life_rule(input logic [8:0] nbhd);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 9; i++) begin
            n = n + ((i != 4) ? 4'(nbhd[i]) : 4'd0);
        end
        return nbhd[4] ? ((n == 4'd2) || (n == 4'd3)) : (n == 4'd3);
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation row from a prev/cur/next row window.
// Edge columns wrap around when LIFE_WRAP_EN is defined, otherwise read as dead.
module life_row_next
    import life_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] prev_row,
    input  logic [WIDTH-1:0] cur_row,
    input  logic [WIDTH-1:0] next_row,
    output logic [WIDTH-1:0] next_gen
);

    // ext[0] is column -1, ext[c+1] is column c, ext[WIDTH+1] is column WIDTH.
    logic [WIDTH+1:0] prev_ext_s;
    logic [WIDTH+1:0] cur_ext_s;
    logic [WIDTH+1:0] next_ext_s;

`ifdef LIFE_WRAP_EN
    assign prev_ext_s = {prev_row[0], prev_row, prev_row[WIDTH-1]};
    assign cur_ext_s  = {cur_row[0],  cur_row,  cur_row[WIDTH-1]};
    assign next_ext_s = {next_row[0], next_row, next_row[WIDTH-1]};
`else
    assign prev_ext_s = {1'b0, prev_row, 1'b0};
    assign cur_ext_s  = {1'b0, cur_row,  1'b0};
    assign next_ext_s = {1'b0, next_row, 1'b0};
`endif

    for (genvar c = 0; c < WIDTH; c++) begin : g_cell
        assign next_gen[c] = life_rule({next_ext_s[c+2:c], cur_ext_s[c+2:c], prev_ext_s[c+2:c]});
    end

endmodule

// File: rtl/life_generation_engine.sv
// Advances a WIDTH x HEIGHT Life grid one generation in place in a row-per-word memory.
// Build with LIFE_WRAP_EN defined for a toroidal grid; default treats off-grid cells as dead.
module life_generation_engine
    import life_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int HEIGHT = 32,
    localparam int ADDR_W = $clog2(HEIGHT),
    localparam int POP_W  = $clog2(WIDTH*HEIGHT+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic [GEN_W-1:0]  gen_count,
    output logic [POP_W-1:0]  pop_count
);

    life_state_e       state_r;
    life_state_e       state_s;
    logic [ADDR_W-1:0] row_r;
    logic [WIDTH-1:0]  prev_r;
    logic [WIDTH-1:0]  cur_r;
    logic [WIDTH-1:0]  next_r;
`ifdef LIFE_WRAP_EN
    logic [WIDTH-1:0]  first_r;
`endif
    logic [POP_W-1:0]  acc_r;

    logic              busy_r;
    logic              done_r;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [WIDTH-1:0]  wr_data_r;
    logic [GEN_W-1:0]  gen_count_r;
    logic [POP_W-1:0]  pop_count_r;

    logic              last_row_s;
    logic [ADDR_W-1:0] row_inc_s;
    logic [ADDR_W-1:0] fetch_row_s;
    logic              fetch_read_s;
    logic [WIDTH-1:0]  next_fill_s;
    logic [WIDTH-1:0]  row_next_s;
    logic [POP_W-1:0]  pop_row_s;
    logic [POP_W-1:0]  acc_sum_s;

    assign last_row_s   = (row_r == ADDR_W'(HEIGHT-1));
    assign row_inc_s    = row_r + ADDR_W'(1);
    assign fetch_row_s  = (state_r == WRITE) ? row_inc_s : {ADDR_W{1'b0}};
    assign fetch_read_s = (fetch_row_s != ADDR_W'(HEIGHT-1));
    assign pop_row_s    = POP_W'(popcount(POP_MAX_W'(wr_data_r)));
    assign acc_sum_s    = acc_r + pop_row_s;

    // Row below the current one: memory data, or the grid edge on the last row.
    always_comb begin
        next_fill_s = rd_data;
        if (last_row_s) begin
`ifdef LIFE_WRAP_EN
            next_fill_s = first_r;
`else
            next_fill_s = {WIDTH{1'b0}};
`endif
        end else begin
            next_fill_s = rd_data;
        end
    end

    // The row result is registered one cycle early so wr_data comes straight from a flop.
    life_row_next #(.WIDTH(WIDTH)) u_row_next (
        .prev_row (prev_r),
        .cur_row  (cur_r),
        .next_row (next_fill_s),
        .next_gen (row_next_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = PRIME0;
                end else begin
                    state_s = IDLE;
                end
            end
            PRIME0: state_s = PRIME1;
`ifdef LIFE_WRAP_EN
            PRIME1: state_s = PRIME2;
`else
            PRIME1: state_s = FETCH;
`endif
            PRIME2:  state_s = PRIME3;
            PRIME3:  state_s = FETCH;
            FETCH:   state_s = CAPTURE;
            CAPTURE: state_s = WRITE;
            WRITE: begin
                if (last_row_s) begin
                    state_s = DONE;
                end else begin
                    state_s = FETCH;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Memory strobes and status flags, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rd_en_r   <= 1'b0;
            rd_addr_r <= {ADDR_W{1'b0}};
        end else begin
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            rd_en_r <= 1'b0;
            case (state_s)
                PRIME0: begin
                    rd_en_r   <= 1'b1;
                    rd_addr_r <= {ADDR_W{1'b0}};
                end
                PRIME2: begin
                    rd_en_r   <= 1'b1;
                    rd_addr_r <= ADDR_W'(HEIGHT-1);
                end
                FETCH: begin
                    rd_en_r   <= fetch_read_s;
                    rd_addr_r <= fetch_read_s ? (fetch_row_s + ADDR_W'(1)) : {ADDR_W{1'b0}};
                end
                default: rd_en_r <= 1'b0;
            endcase
        end
    end

    // Row window, write-back port and population accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_r     <= {ADDR_W{1'b0}};
            prev_r    <= {WIDTH{1'b0}};
            cur_r     <= {WIDTH{1'b0}};
            next_r    <= {WIDTH{1'b0}};
`ifdef LIFE_WRAP_EN
            first_r   <= {WIDTH{1'b0}};
`endif
            acc_r     <= {POP_W{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {WIDTH{1'b0}};
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        row_r <= {ADDR_W{1'b0}};
                        acc_r <= {POP_W{1'b0}};
                    end
                end
                PRIME1: begin
                    cur_r  <= rd_data;
                    prev_r <= {WIDTH{1'b0}};
`ifdef LIFE_WRAP_EN
                    first_r <= rd_data;
`endif
                end
                PRIME3: prev_r <= rd_data;
                CAPTURE: begin
                    next_r    <= next_fill_s;
                    wr_data_r <= row_next_s;
                    wr_addr_r <= row_r;
                    wr_en_r   <= 1'b1;
                end
                WRITE: begin
                    prev_r <= cur_r;
                    cur_r  <= next_r;
                    acc_r  <= acc_sum_s;
                    if (!last_row_s) begin
                        row_r <= row_inc_s;
                    end
                end
                default: wr_en_r <= 1'b0;
            endcase
        end
    end

    // Generation and population statistics, published as DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_count_r <= {GEN_W{1'b0}};
            pop_count_r <= {POP_W{1'b0}};
        end else if ((state_r == WRITE) && last_row_s) begin
            gen_count_r <= gen_count_r + GEN_W'(1);
            pop_count_r <= acc_sum_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign rd_en     = rd_en_r;
    assign rd_addr   = rd_addr_r;
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign gen_count = gen_count_r;
    assign pop_count = pop_count_r;

endmodule
